// File: rtl/powlib_step_cntr.sv
// W-bit counter that steps by a signed constant X, with clear, optional load and async reset.
// Define POWLIB_CNTR_WRAP_EN to add the registered wrap output (overflow/borrow flag).
module powlib_step_cntr #(
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] X    = W'(1),
  parameter logic [W-1:0] INIT = '0,
  parameter int unsigned  ELD  = 1,
  parameter int unsigned  EAR  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] nval,
  input  logic         adv,
  input  logic         ld,
  input  logic         clr,
  output logic [W-1:0] cntr
`ifdef POWLIB_CNTR_WRAP_EN
  ,
  output logic         wrap
`endif
);

  if (EAR != 1 || W < 1) begin : g_param_chk
    $error("powlib_step_cntr: EAR must be 1 and W must be >= 1");
  end

  logic [W-1:0] cntr_q, cntr_d;
  logic [W:0]   sum;
  logic         ld_en;

  // Extra top bit captures the carry out of the modular add.
  assign sum   = {1'b0, cntr_q} + {1'b0, X};
  assign ld_en = (ELD != 0) && ld;

  always_comb begin
    cntr_d = cntr_q;
    if (clr) begin
      cntr_d = INIT;
    end else if (ld_en) begin
      cntr_d = nval;
    end else if (adv) begin
      cntr_d = sum[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntr_q <= INIT;
    end else begin
      cntr_q <= cntr_d;
    end
  end

  assign cntr = cntr_q;

`ifdef POWLIB_CNTR_WRAP_EN
  logic wrap_q, wrap_d;

  // Positive step wraps on carry out; negative step wraps on borrow (no carry).
  always_comb begin
    wrap_d = 1'b0;
    if (!clr && !ld_en && adv) begin
      wrap_d = X[W-1] ? !sum[W] : sum[W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_powlib_step_cntr.sv
// Self-checking bench for powlib_step_cntr: four instances (up, down, INIT=0x3C, ELD=0 with X=3)
// share stimulus and are compared against an arithmetic reference model.
module tb_powlib_step_cntr;

  localparam int XS    [4] = '{1, -1, 1, 3};
  localparam int INITV [4] = '{0, 0, 'h3C, 0};
  localparam int ELDV  [4] = '{1, 1, 1, 0};

  logic       clk;
  logic       rst;
  logic       adv, ld, clr;
  logic [7:0] nval;
  logic [7:0] dq [4];
  logic       dw [4];

  int compared   = 0;
  int mismatched = 0;
  int mdl [4];
  bit mw  [4];

  powlib_step_cntr #(.W(8), .X(8'd1), .INIT(8'h00), .ELD(1), .EAR(1)) u0 (
    .clk(clk), .rst(rst), .nval(nval), .adv(adv), .ld(ld), .clr(clr), .cntr(dq[0])
`ifdef POWLIB_CNTR_WRAP_EN
    , .wrap(dw[0])
`endif
  );
  powlib_step_cntr #(.W(8), .X(8'hFF), .INIT(8'h00), .ELD(1), .EAR(1)) u1 (
    .clk(clk), .rst(rst), .nval(nval), .adv(adv), .ld(ld), .clr(clr), .cntr(dq[1])
`ifdef POWLIB_CNTR_WRAP_EN
    , .wrap(dw[1])
`endif
  );
  powlib_step_cntr #(.W(8), .X(8'd1), .INIT(8'h3C), .ELD(1), .EAR(1)) u2 (
    .clk(clk), .rst(rst), .nval(nval), .adv(adv), .ld(ld), .clr(clr), .cntr(dq[2])
`ifdef POWLIB_CNTR_WRAP_EN
    , .wrap(dw[2])
`endif
  );
  powlib_step_cntr #(.W(8), .X(8'd3), .INIT(8'h00), .ELD(0), .EAR(1)) u3 (
    .clk(clk), .rst(rst), .nval(nval), .adv(adv), .ld(ld), .clr(clr), .cntr(dq[3])
`ifdef POWLIB_CNTR_WRAP_EN
    , .wrap(dw[3])
`endif
  );

`ifndef POWLIB_CNTR_WRAP_EN
  initial for (int i = 0; i < 4; i++) dw[i] = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit              clr;
    bit              ld;
    bit              adv;
    logic [7:0]      nval;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vt [9];

  function automatic vec_t mk(bit c, bit l, bit a, logic [7:0] n,
                              logic [7:0] e0, logic [7:0] e1, logic [7:0] e2, logic [7:0] e3);
    vec_t v;
    v.clr = c; v.ld = l; v.adv = a; v.nval = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mdl[i] = INITV[i];
      mw[i]  = 1'b0;
    end
  endtask

  // Reference: signed arithmetic on integers; a sum outside 0..255 is a wrap.
  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      int s;
      mw[i] = 1'b0;
      if (clr) begin
        mdl[i] = INITV[i];
      end else if (ld && ELDV[i] != 0) begin
        mdl[i] = int'(nval);
      end else if (adv) begin
        s      = mdl[i] + XS[i];
        mw[i]  = (s > 255) || (s < 0);
        mdl[i] = ((s % 256) + 256) % 256;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cntr_u%0d", i), dq[i], 8'(mdl[i]));
`ifdef POWLIB_CNTR_WRAP_EN
      chk($sformatf("wrap_u%0d", i), {7'b0, dw[i]}, {7'b0, mw[i]});
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input bit c, input bit l, input bit a, input logic [7:0] n);
    clr = c; ld = l; adv = a; nval = n;
  endtask

  // Called just after a rising edge: raise rst between edges, check, release before next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
  endtask

  int wrap_cnt;

  initial begin
    vt[0] = mk(0, 1, 1, 8'h10, 8'h10, 8'h10, 8'h10, 8'h03);
    vt[1] = mk(0, 1, 1, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h06);
    vt[2] = mk(0, 0, 1, 8'h00, 8'hA6, 8'hA4, 8'hA6, 8'h09);
    vt[3] = mk(1, 1, 1, 8'h55, 8'h00, 8'h00, 8'h3C, 8'h00);
    vt[4] = mk(0, 1, 0, 8'h99, 8'h99, 8'h99, 8'h99, 8'h00);
    vt[5] = mk(0, 1, 1, 8'h99, 8'h99, 8'h99, 8'h99, 8'h03);
    vt[6] = mk(0, 0, 0, 8'h77, 8'h99, 8'h99, 8'h99, 8'h03);
    vt[7] = mk(0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
    vt[8] = mk(0, 0, 1, 8'h00, 8'h01, 8'hFF, 8'h01, 8'h06);

    rst = 1'b1;
    drive(0, 0, 0, 8'h00);
    #3;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      drive(vt[k].clr, vt[k].ld, vt[k].adv, vt[k].nval);
      cycle();
      for (int i = 0; i < 4; i++)
        chk($sformatf("vec%0d_u%0d", k, i), dq[i], vt[k].exp[i]);
    end
`ifdef POWLIB_CNTR_WRAP_EN
    chk("vec8_down_wrap", {7'b0, dw[1]}, 8'h01);
`endif

    drive(1, 0, 0, 8'h00);
    cycle();
    drive(0, 0, 1, 8'h00);
    wrap_cnt = 0;
    for (int n = 1; n <= 257; n++) begin
      cycle();
      if (dw[0] === 1'b1) wrap_cnt++;
      if (n == 1) chk("down_0_to_ff", dq[1], 8'hFF);
      if (n == 3) chk("down_to_fd", dq[1], 8'hFD);
      if (n == 255) chk("up_at_ff", dq[0], 8'hFF);
      if (n == 256) chk("up_wrap_00", dq[0], 8'h00);
    end
    chk("up_after_257", dq[0], 8'h01);
`ifdef POWLIB_CNTR_WRAP_EN
    chk("up_wrap_pulses", 8'(wrap_cnt), 8'd1);
`endif

    drive(0, 1, 0, 8'h37);
    cycle();
    chk("pre_reset_37", dq[0], 8'h37);
    drive(0, 0, 1, 8'h00);
    async_reset();
    chk("async_reset_u0", dq[0], 8'h00);
    chk("async_reset_u2", dq[2], 8'h3C);
    drive(0, 0, 0, 8'h00);
    cycle();
    cycle();
    chk("hold_after_reset", dq[0], 8'h00);
    drive(0, 0, 1, 8'h00);
    cycle();
    chk("first_adv_after_reset", dq[0], 8'h01);

    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 16) == 0, ($urandom % 4) == 0, ($urandom % 2) == 1, 8'($urandom));
      if (($urandom % 64) == 0) async_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
